// File: rtl/riscv_io_bus_bridge.sv
// Data-side bridge from the multicycle RISC-V core to data memory and I/O channels.
// One access at a time: decode, strobe one target, wait for completion, pulse ready.
module riscv_io_bus_bridge #(
   parameter logic [31:0] DATA_START_ADDRESS = 32'h0000_2000,
   parameter int unsigned DATA_DEPTH_WORDS   = 2048,
   parameter logic [31:0] IO_START_ADDRESS   = 32'h0000_7F00,
   parameter int unsigned NUM_IO_CH          = 4,
   parameter int unsigned IO_CH_BYTES        = 64,
   parameter int unsigned IO_TIMEOUT         = 15,
   parameter logic [31:0] ERR_DATA           = 32'h0000_0000,
   localparam int unsigned OFF_W = $clog2(IO_CH_BYTES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               address,
   input  logic                      MemRead,
   input  logic                      MemWrite,
   input  logic [31:0]               wdata,
   output logic [31:0]               rdata,
   output logic                      ready,
   output logic                      bus_error,
   output logic                      busy,
   output logic [15:0]               err_count,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic [31:0]               mem_addr,
   output logic [31:0]               mem_wdata,
   input  logic [31:0]               mem_rdata,
   output logic [NUM_IO_CH-1:0]      io_sel,
   output logic                      io_read,
   output logic                      io_write,
   output logic [OFF_W-1:0]          io_offset,
   output logic [31:0]               io_wdata,
   input  logic [32*NUM_IO_CH-1:0]   io_rdata,
   input  logic [NUM_IO_CH-1:0]      io_valid
);

   localparam int unsigned CH_W  = (NUM_IO_CH > 1) ? $clog2(NUM_IO_CH) : 1;
   localparam int unsigned CNT_W = $clog2(IO_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_MEM, S_IO, S_ERR, S_MEM_RESP, S_IO_WAIT, S_RESP
   } state_t;

   state_t               r_state;
   logic [31:0]          r_addr;
   logic [31:0]          r_wdata;
   logic                 r_write;
   logic [CH_W-1:0]      r_ch;
   logic [OFF_W-1:0]     r_io_offset;
   logic [CNT_W-1:0]     r_wait_cnt;
   logic [31:0]          r_rdata;
   logic                 r_ready;
   logic                 r_bus_error;
   logic                 r_busy;
   logic [15:0]          r_err_count;
   logic                 r_mem_read;
   logic                 r_mem_write;
   logic                 r_io_read;
   logic                 r_io_write;
   logic [NUM_IO_CH-1:0] r_io_sel;

   // 33-bit offsets: an address below a region base wraps to a huge value and fails the bound
   logic [32:0]          w_data_rel;
   logic [32:0]          w_io_rel;
   logic                 w_is_mem;
   logic                 w_is_io;
   logic                 w_err;
   logic [CH_W-1:0]      w_ch;
   logic [31:0]          w_io_data;

   assign w_data_rel = {1'b0, address} - {1'b0, DATA_START_ADDRESS};
   assign w_io_rel   = {1'b0, address} - {1'b0, IO_START_ADDRESS};
   assign w_is_mem   = (w_data_rel < 33'(4 * DATA_DEPTH_WORDS));
   assign w_is_io    = (w_io_rel < 33'(NUM_IO_CH * IO_CH_BYTES));
   assign w_ch       = w_io_rel[OFF_W +: CH_W];
   assign w_err      = (MemRead & MemWrite) | (address[1:0] != 2'b00) | (!w_is_mem & !w_is_io);
   assign w_io_data  = io_rdata[32*r_ch +: 32];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_write     <= 1'b0;
         r_ch        <= '0;
         r_io_offset <= '0;
         r_wait_cnt  <= '0;
         r_rdata     <= '0;
         r_ready     <= 1'b0;
         r_bus_error <= 1'b0;
         r_busy      <= 1'b0;
         r_err_count <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_io_read   <= 1'b0;
         r_io_write  <= 1'b0;
         r_io_sel    <= '0;
      end else begin
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_io_read   <= 1'b0;
         r_io_write  <= 1'b0;
         r_io_sel    <= '0;
         r_ready     <= 1'b0;
         r_bus_error <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (MemRead | MemWrite) begin
                  r_addr      <= address;
                  r_wdata     <= wdata;
                  r_write     <= MemWrite;
                  r_ch        <= w_ch;
                  r_io_offset <= w_io_rel[OFF_W-1:0];
                  r_busy      <= 1'b1;
                  if (w_err) begin
                     r_state <= S_ERR;
                  end else if (w_is_mem) begin
                     r_state     <= S_MEM;
                     r_mem_read  <= ~MemWrite;
                     r_mem_write <= MemWrite;
                  end else begin
                     r_state    <= S_IO;
                     r_io_sel   <= NUM_IO_CH'(1) << w_ch;
                     r_io_read  <= ~MemWrite;
                     r_io_write <= MemWrite;
                  end
               end
            end
            S_ERR: begin
               r_state     <= S_RESP;
               r_ready     <= 1'b1;
               r_bus_error <= 1'b1;
               r_rdata     <= ERR_DATA;
               if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
            S_MEM: begin
               if (r_write) begin
                  r_state <= S_RESP;
                  r_ready <= 1'b1;
               end else begin
                  r_state <= S_MEM_RESP;
               end
            end
            S_MEM_RESP: begin
               r_rdata <= mem_rdata;
               r_state <= S_RESP;
               r_ready <= 1'b1;
            end
            S_IO: begin
               r_wait_cnt <= '0;
               if (r_write) begin
                  r_state <= S_RESP;
                  r_ready <= 1'b1;
               end else begin
                  r_state <= S_IO_WAIT;
               end
            end
            S_IO_WAIT: begin
               // valid in the expiring cycle still wins over the timeout
               if (io_valid[r_ch]) begin
                  r_rdata <= w_io_data;
                  r_state <= S_RESP;
                  r_ready <= 1'b1;
               end else if (r_wait_cnt == CNT_W'(IO_TIMEOUT - 1)) begin
                  r_state     <= S_RESP;
                  r_ready     <= 1'b1;
                  r_bus_error <= 1'b1;
                  r_rdata     <= ERR_DATA;
                  if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rdata     = r_rdata;
   assign ready     = r_ready;
   assign bus_error = r_bus_error;
   assign busy      = r_busy;
   assign err_count = r_err_count;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign io_sel    = r_io_sel;
   assign io_read   = r_io_read;
   assign io_write  = r_io_write;
   assign io_offset = r_io_offset;
   assign io_wdata  = r_wdata;

endmodule

// File: tb/tb_riscv_io_bus_bridge.sv
// Scoreboard bench for riscv_io_bus_bridge: directed accesses queue expected
// responses, a monitor pops and compares on every ready pulse.
module tb_riscv_io_bus_bridge;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  address = '0;
   logic         MemRead = 1'b0;
   logic         MemWrite = 1'b0;
   logic [31:0]  wdata = '0;
   logic [31:0]  rdata;
   logic         ready;
   logic         bus_error;
   logic         busy;
   logic [15:0]  err_count;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata = '0;
   logic [3:0]   io_sel;
   logic         io_read;
   logic         io_write;
   logic [5:0]   io_offset;
   logic [31:0]  io_wdata;
   logic [127:0] io_rdata = '0;
   logic [3:0]   io_valid = '0;

   riscv_io_bus_bridge dut (
      .clk(clk), .rst(rst), .address(address), .MemRead(MemRead), .MemWrite(MemWrite),
      .wdata(wdata), .rdata(rdata), .ready(ready), .bus_error(bus_error), .busy(busy),
      .err_count(err_count), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .io_sel(io_sel), .io_read(io_read),
      .io_write(io_write), .io_offset(io_offset), .io_wdata(io_wdata), .io_rdata(io_rdata),
      .io_valid(io_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous data RAM behind the bridge
   logic [31:0] mem [0:2047];
   initial for (int i = 0; i < 2048; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (mem_write) mem[(mem_addr - 32'h2000) >> 2] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[(mem_addr - 32'h2000) >> 2];
   end

   typedef struct {
      string       nm;
      logic [31:0] rdata;
      logic        berr;
      logic [15:0] ec;
   } exp_t;
   exp_t q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int t0       = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic expect_resp(input string nm, input logic [31:0] rd, input logic be, input logic [15:0] ec);
      exp_t e;
      e.nm = nm; e.rdata = rd; e.berr = be; e.ec = ec;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (ready) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ready: got ready=1, required no pending access");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.nm, "_rdata"}, rdata, e.rdata);
            chk({e.nm, "_bus_error"}, bus_error, e.berr);
            chk({e.nm, "_err_count"}, err_count, e.ec);
         end
      end
   end

   // drives the request for cycle 0 and returns at the cycle-1 sample point
   task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      MemRead = rd; MemWrite = wr; address = a; wdata = d;
      t0 = cyc;
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0; address = 32'hFFFF_FFF0; wdata = 32'h0BAD_0BAD;
   endtask

   task automatic wait_ready(input string nm, input int lat);
      int n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready) chk({nm, "_ready_timeout"}, 64'd0, 64'd1);
      else begin
         chk({nm, "_latency"}, 64'(cyc - t0), 64'(lat));
         chk({nm, "_busy"}, busy, 1'b1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {ready, bus_error, busy, mem_read, mem_write, io_read, io_write, io_sel}, '0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_err_count", err_count, 16'h0);
      rst = 1'b0;

      // memory write then read-back
      expect_resp("mem_wr", 32'h0, 1'b0, 16'd0);
      req(1'b0, 1'b1, 32'h2000, 32'hCAFE_F00D);
      chk("mem_wr_strobes", {mem_read, mem_write, io_read, io_write, io_sel}, 8'b0100_0000);
      chk("mem_wr_addr", mem_addr, 32'h2000);
      chk("mem_wr_data", mem_wdata, 32'hCAFE_F00D);
      wait_ready("mem_wr", 2);

      expect_resp("mem_rd", 32'hCAFE_F00D, 1'b0, 16'd0);
      req(1'b1, 1'b0, 32'h2000, 32'h0);
      chk("mem_rd_strobes", {mem_read, mem_write, io_read, io_write, io_sel}, 8'b1000_0000);
      wait_ready("mem_rd", 3);

      // channel 1 read, valid 3 cycles after strobe, other channels valid earlier
      io_rdata = {32'h3333_3333, 32'h2222_2222, 32'h0000_1234, 32'h1111_1111};
      expect_resp("io_rd", 32'h0000_1234, 1'b0, 16'd0);
      req(1'b1, 1'b0, 32'h7F44, 32'h0);
      chk("io_rd_strobes", {mem_read, mem_write, io_read, io_write, io_sel}, 8'b0010_0010);
      chk("io_rd_offset", io_offset, 6'd4);
      io_valid = 4'b1101;
      repeat (3) @(negedge clk);
      io_valid = 4'b1111;
      wait_ready("io_rd", 5);
      io_valid = 4'b0000;

      // channel 2 write completes without any valid
      expect_resp("io_wr", 32'h0000_1234, 1'b0, 16'd0);
      req(1'b0, 1'b1, 32'h7F84, 32'h55AA_55AA);
      chk("io_wr_strobes", {mem_read, mem_write, io_read, io_write, io_sel}, 8'b0001_0100);
      chk("io_wr_offset", io_offset, 6'd4);
      chk("io_wr_data", io_wdata, 32'h55AA_55AA);
      wait_ready("io_wr", 2);

      // channel 0 read times out; valid on channel 2 must not rescue it
      expect_resp("io_tmo", 32'h0, 1'b1, 16'd1);
      req(1'b1, 1'b0, 32'h7F00, 32'h0);
      chk("io_tmo_sel", io_sel, 4'b0001);
      io_valid = 4'b0100;
      wait_ready("io_tmo", 17);
      io_valid = 4'b0000;

      // reset while waiting on an I/O read drops the access
      req(1'b1, 1'b0, 32'h7F00, 32'h0);
      chk("drop_strobe", io_read, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("drop_ctrl", {ready, bus_error, busy, mem_read, mem_write, io_read, io_write, io_sel}, '0);
      chk("drop_data", {rdata, err_count, io_offset}, '0);
      chk("drop_addr", {mem_addr, mem_wdata, io_wdata}, '0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("drop_idle_busy", busy, 1'b0);

      expect_resp("post_rst_rd", 32'hCAFE_F00D, 1'b0, 16'd0);
      req(1'b1, 1'b0, 32'h2000, 32'h0);
      chk("post_rst_strobe", mem_read, 1'b1);
      wait_ready("post_rst_rd", 3);

      // unmapped, misaligned and conflicting requests, back to back
      expect_resp("unmapped", 32'h0, 1'b1, 16'd1);
      req(1'b1, 1'b0, 32'h4000, 32'h0);
      chk("unmapped_nostrobe", {mem_read, mem_write, io_read, io_write, io_sel}, '0);
      wait_ready("unmapped", 2);

      expect_resp("misalign", 32'h0, 1'b1, 16'd2);
      req(1'b0, 1'b1, 32'h2002, 32'h1234_5678);
      chk("misalign_nostrobe", {mem_read, mem_write, io_read, io_write, io_sel}, '0);
      wait_ready("misalign", 2);

      expect_resp("conflict", 32'h0, 1'b1, 16'd3);
      req(1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF);
      chk("conflict_nostrobe", {mem_read, mem_write, io_read, io_write, io_sel}, '0);
      wait_ready("conflict", 2);

      repeat (3) @(negedge clk);
      chk("mem_untouched", mem[0], 32'hCAFE_F00D);
      chk("queue_empty", 64'(q.size()), 64'd0);
      chk("final_err_count", err_count, 16'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
